mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, number of MAR bits driven to memory.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack (range 2..255).
REQ-003 clock  in  1  the only clock; all state updates on its rising edge.
REQ-004 clear  in  1  reset, synchronous, active-high.
REQ-005 bus_data  in  32  value currently on the datapath bus.
REQ-006 mar_in  in  1  load MAR from bus_data.
REQ-007 mdr_in  in  1  load MDR from bus_data.
REQ-008 rd_req  in  1  start a memory read into MDR.
REQ-009 wr_req  in  1  start a memory write of MDR.
REQ-010 mem_rdata  in  32  memory read data, valid while mem_ack=1.
REQ-011 mem_ack  in  1  memory completion strobe.
REQ-012 mem_addr  out  ADDR_W  MAR[ADDR_W-1:0].
REQ-013 mem_wdata  out  32  current MDR value.
REQ-014 mem_re  out  1  registered read strobe.
REQ-015 mem_we  out  1  registered write strobe.
REQ-016 mdr_q  out  32  MDR value, feeds the bus multiplexer MDR input (select 21).
REQ-017 busy  out  1  high in READ or WRITE.
REQ-018 done  out  1  one-cycle pulse on successful completion.
REQ-019 err  out  1  one-cycle pulse on timeout.

Function
REQ-020 The FSM SHALL have three states: IDLE, READ, WRITE.
REQ-021 In IDLE, if rd_req=1, next state SHALL be READ; else if wr_req=1, next state SHALL be WRITE. rd_req wins when both are set, and the write is dropped.
REQ-022 mem_re SHALL equal 1 exactly while in READ; mem_we SHALL equal 1 exactly while in WRITE; both are registered, so they rise one cycle after the request is sampled.
REQ-023 rd_req and wr_req sampled outside IDLE SHALL be ignored (no queuing).
REQ-024 In IDLE, mar_in=1 SHALL load MAR and mdr_in=1 SHALL load MDR from bus_data; both may load in the same cycle.
REQ-025 mar_in and mdr_in SHALL be ignored while busy=1; MAR and MDR are stable for the whole transaction.
REQ-026 In READ with mem_ack=1, MDR SHALL capture mem_rdata, the state SHALL return to IDLE, and done SHALL be 1 in the following cycle.
REQ-027 In WRITE with mem_ack=1, the state SHALL return to IDLE, and done SHALL be 1 in the following cycle; MDR is unchanged.
REQ-028 A wait counter SHALL reset to 0 on entering READ or WRITE and increment each cycle without ack.
REQ-029 If the counter equals TIMEOUT-1 and mem_ack=0, the state SHALL return to IDLE and err SHALL pulse in the next cycle, leaving MDR unchanged. The strobe is therefore high for exactly TIMEOUT cycles.
REQ-030 mem_ack on the timeout cycle SHALL count as success (done, not err).
REQ-031 mem_ack sampled in IDLE SHALL be ignored.
REQ-032 A new request SHALL be accepted in the same cycle done or err is high (back-to-back transactions, one idle cycle between strobes).
REQ-033 done and err SHALL never be high together; busy SHALL be 0 whenever done or err is 1.

Reset
REQ-034 clear=1 SHALL force IDLE, MAR=0, MDR=0, counter=0, mem_re=0, mem_we=0, done=0, err=0 on the next edge, aborting any transaction in flight without a done or err pulse.
REQ-035 clear SHALL override all other inputs in the same cycle.

Verification
REQ-036 Load: bus_data=0x0000_0055 with mar_in, then 0xDEAD_BEEF with mdr_in -> mem_addr=0x055, mdr_q=0xDEADBEEF, busy=0.
REQ-037 Read: rd_req at cycle t; mem_ack with mem_rdata=0x1234_5678 at t+3 -> mem_re high t+1..t+3, mdr_q=0x12345678 and done=1 at t+4, busy=0.
REQ-038 Write: MDR=0xA5A5_A5A5, wr_req at t, mem_ack at t+2 -> mem_we high t+1..t+2, mem_wdata=0xA5A5A5A5 throughout, done at t+3; mdr_in=1 with bus_data=0 during t+1 leaves MDR unchanged.
REQ-039 Timeout: TIMEOUT=15, rd_req, no ack -> mem_re high 15 cycles, err pulse 1 cycle, MDR unchanged. Repeat with ack on the 15th cycle -> done, no err.
REQ-040 Simultaneous: rd_req=wr_req=1 in IDLE -> READ only, mem_we never asserted. wr_req during READ -> ignored.
REQ-041 Reset mid-read: clear at second cycle of READ -> next cycle all outputs 0, no done or err, later mem_ack ignored.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Memory port controller: MAR/MDR registers and a read/write handshake
// FSM with a bounded wait for the memory acknowledge.
module mem_port_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       bus_data,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] mar, mar_n;
  logic [31:0]       mdr, mdr_n;
  logic [7:0]        cnt, cnt_n;
  logic              done_n, err_n;

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      mar    <= '0;
      mdr    <= '0;
      cnt    <= '0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      mar    <= mar_n;
      mdr    <= mdr_n;
      cnt    <= cnt_n;
      mem_re <= (state_n == READ);
      mem_we <= (state_n == WRITE);
      done   <= done_n;
      err    <= err_n;
    end
  end

  // Ack on the last wait cycle still wins over the timeout.
  always_comb begin
    state_n = state;
    mar_n   = mar;
    mdr_n   = mdr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mar_in) mar_n = bus_data[ADDR_W-1:0];
        if (mdr_in) mdr_n = bus_data;
        if (rd_req) begin
          state_n = READ;
          cnt_n   = '0;
        end else if (wr_req) begin
          state_n = WRITE;
          cnt_n   = '0;
        end
      end
      READ, WRITE: begin
        if (mem_ack) begin
          if (state == READ) mdr_n = mem_rdata;
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mdr_q     = mdr;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: transaction-level model compared every cycle
// plus directed scenarios with literal expectations.
module tb_mem_port_ctrl;

  localparam int AW = 9;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   bus_data = '0;
  logic          mar_in = 1'b0;
  logic          mdr_in = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [31:0]   mdr_q;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  mem_port_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .clear(clear), .bus_data(bus_data),
    .mar_in(mar_in), .mdr_in(mdr_in), .rd_req(rd_req),
    .wr_req(wr_req), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_we(mem_we), .mdr_q(mdr_q), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: op 0=none 1=read 2=write; age = strobe cycles so far.
  int          op = 0;
  int          age = 0;
  logic [31:0] m_mar = '0;
  logic [31:0] m_mdr = '0;
  bit          m_done = 0;
  bit          m_err = 0;

  always @(posedge clock) begin
    if (clear) begin
      op = 0; age = 0; m_mar = '0; m_mdr = '0;
      m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err = 0;
      if (op == 0) begin
        if (mar_in) m_mar = bus_data % (1 << AW);
        if (mdr_in) m_mdr = bus_data;
        if (rd_req) begin op = 1; age = 1; end
        else if (wr_req) begin op = 2; age = 1; end
      end else if (mem_ack) begin
        if (op == 1) m_mdr = mem_rdata;
        m_done = 1;
        op = 0;
      end else if (age == TO) begin
        m_err = 1;
        op = 0;
      end else begin
        age++;
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("m_addr", 32'(mem_addr), m_mar);
      chk("m_wdata", mem_wdata, m_mdr);
      chk("m_mdr", mdr_q, m_mdr);
      chk("m_re", 32'(mem_re), 32'(op == 1));
      chk("m_we", 32'(mem_we), 32'(op == 2));
      chk("m_busy", 32'(busy), 32'(op != 0));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_err", 32'(err), 32'(m_err));
      chk("m_excl", 32'(done & err), 32'd0);
      chk("m_busyx", 32'(busy & (done | err)), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    checking = 1;
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_mdr", mdr_q, 32'd0);
    chk("rst_strb", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);

    // Load MAR then MDR
    bus_data = 32'h0000_0055; mar_in = 1'b1; tick();
    mar_in = 1'b0; bus_data = 32'hDEAD_BEEF; mdr_in = 1'b1; tick();
    mdr_in = 1'b0;
    chk("ld_addr", 32'(mem_addr), 32'h055);
    chk("ld_mdr", mdr_q, 32'hDEAD_BEEF);
    chk("ld_busy", 32'(busy), 32'd0);

    // Read, ack on third strobe cycle
    rd_req = 1'b1; tick();
    rd_req = 1'b0;
    chk("rd_re1", 32'(mem_re), 32'd1);
    tick();
    chk("rd_re2", 32'(mem_re), 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    chk("rd_re3", 32'(mem_re), 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_mdr", mdr_q, 32'h1234_5678);
    chk("rd_busy", 32'(busy), 32'd0);
    chk("rd_re4", 32'(mem_re), 32'd0);

    // Write; MDR load attempt while busy is ignored
    bus_data = 32'hA5A5_A5A5; mdr_in = 1'b1; tick();
    mdr_in = 1'b0;
    wr_req = 1'b1; tick();
    wr_req = 1'b0;
    chk("wr_we1", 32'(mem_we), 32'd1);
    chk("wr_wd1", mem_wdata, 32'hA5A5_A5A5);
    mdr_in = 1'b1; bus_data = 32'h0; tick();
    mdr_in = 1'b0;
    chk("wr_we2", 32'(mem_we), 32'd1);
    chk("wr_wd2", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_we3", 32'(mem_we), 32'd0);
    chk("wr_mdr", mdr_q, 32'hA5A5_A5A5);

    // Timeout without ack
    rd_req = 1'b1; tick();
    rd_req = 1'b0;
    n = 0;
    while (mem_re && n < 20) begin
      n++;
      tick();
    end
    chk("to_len", 32'(n), 32'd15);
    chk("to_err", 32'(err), 32'd1);
    chk("to_done", 32'(done), 32'd0);
    chk("to_mdr", mdr_q, 32'hA5A5_A5A5);
    tick();
    chk("to_err1", 32'(err), 32'd0);

    // Ack on the final wait cycle counts as success
    rd_req = 1'b1; tick();
    rd_req = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("ta_re15", 32'(mem_re), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; tick();
    mem_ack = 1'b0;
    chk("ta_done", 32'(done), 32'd1);
    chk("ta_err", 32'(err), 32'd0);
    chk("ta_mdr", mdr_q, 32'hCAFE_F00D);

    // Simultaneous requests, then write during read, then back-to-back
    rd_req = 1'b1; wr_req = 1'b1; tick();
    rd_req = 1'b0;
    chk("sim_re", 32'(mem_re), 32'd1);
    chk("sim_we", 32'(mem_we), 32'd0);
    tick();
    wr_req = 1'b0;
    chk("sim_we2", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; tick();
    mem_ack = 1'b0;
    chk("sim_done", 32'(done), 32'd1);
    wr_req = 1'b1; tick();
    wr_req = 1'b0;
    chk("b2b_we", 32'(mem_we), 32'd1);
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_mdr", mdr_q, 32'h0BAD_F00D);

    // Clear in the second read cycle aborts silently
    rd_req = 1'b1; tick();
    rd_req = 1'b0; tick();
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("clr_strb", {30'd0, mem_re, mem_we}, 32'd0);
    chk("clr_flags", {29'd0, busy, done, err}, 32'd0);
    chk("clr_mdr", mdr_q, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777; tick();
    mem_ack = 1'b0;
    chk("clr_ack", {29'd0, busy, done, err}, 32'd0);
    chk("clr_mdr2", mdr_q, 32'd0);
    tick();
    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
